in_port_bank: RTL
=================

IN_PORT_BANK -- requirements
Module: in_port_bank

Interface
REQ-001 SHALL have parameter D_WIDTH, default 34: width of one data word.
REQ-002 SHALL have parameter PA_WIDTH, default 4: port address width, giving 2**PA_WIDTH input ports.
REQ-003 SHALL have parameter TIMEOUT, default 255: cycles to wait on an empty port before a forced ack (see REQ-021).
REQ-004 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i, input, 1: synchronous active-high reset.
REQ-006 SHALL have port in_req_i, input, 1: core read request; driven by the core's in_req_o.
REQ-007 SHALL have port in_addr_i, input, PA_WIDTH: port being read; driven by the core's in_addr_o.
REQ-008 SHALL have port in_data_o, output, D_WIDTH: read data; drives the core's in_data_i.
REQ-009 SHALL have port in_ack_o, output, 1: read acknowledge; drives the core's in_ack_i.
REQ-010 SHALL have port ext_wr_i, input, 1: external producer write strobe.
REQ-011 SHALL have port ext_addr_i, input, PA_WIDTH: target port of the external write.
REQ-012 SHALL have port ext_data_i, input, D_WIDTH: external write data.
REQ-013 SHALL have port ext_ready_o, output, 1: addressed slot can accept a write this cycle.
REQ-014 SHALL have port port_valid_o, output, 2**PA_WIDTH: per-port slot-full flags.

Function
REQ-015 SHALL hold one D_WIDTH data slot and one valid bit per port.
REQ-016 SHALL drive ext_ready_o = !valid[ext_addr_i] combinationally; a write occurs only when ext_wr_i && ext_ready_o, storing the data and setting valid at the next edge.
REQ-017 SHALL implement FSM IDLE -> ACK -> RELEASE -> IDLE, plus WAIT.
- IDLE: on in_req_i, latch in_addr_i. Go to ACK if valid[in_addr_i]=1, otherwise go to WAIT.
- WAIT: go to ACK once the latched slot becomes valid.
REQ-018 SHALL, on entering ACK, register the slot data onto in_data_o, assert in_ack_o for exactly one cycle, and clear that slot's valid bit.
- Ack latency from a request on a full slot is 1 cycle.
REQ-019 SHALL hold in_data_o stable from the ack until the next ack.
- In RELEASE, the FSM returns to IDLE only after in_req_i is sampled low (four-phase handshake).
- A re-raised request is never acked twice from one sample.
REQ-020 SHALL treat an external write to the port being waited on as making data available.
- The write lands at edge N and the ack is asserted in the cycle after edge N+1.
- A write to a full slot is not accepted (ext_ready_o=0) and is not lost from the producer's view.
REQ-021 SHALL, in WAIT with IN_PORT_TIMEOUT_EN defined, count cycles.
- On reaching TIMEOUT, ack with in_data_o = 0 and bit D_WIDTH-1 set as a timeout marker; slot state is unchanged.
REQ-022 SHALL ignore changes of in_addr_i while not in IDLE.
REQ-023 SHALL drive port_valid_o directly from the valid bits.

Reset
REQ-024 SHALL, when reset_i is high at an edge, clear all valid bits, set the FSM to IDLE, set in_ack_o=0, set in_data_o=0 and clear the timeout counter.
- This applies in any state, including mid-ACK and mid-WAIT.
REQ-025 SHALL ignore ext_wr_i during any cycle in which reset_i is high.
REQ-026 SHALL keep port_valid_o all-zero from the first post-reset cycle until a write is accepted.

Configuration
REQ-027 SHALL compile the WAIT timeout counter and forced ack only when the macro IN_PORT_TIMEOUT_EN is defined.
- Without the macro, WAIT persists indefinitely until data arrives.
- Without the macro, the TIMEOUT parameter has no effect.

Verification
REQ-028 SHALL cover: write 0x2_0000_0001 to port 3, then raise in_req_i with addr 3 -> in_ack_o high one cycle after req with in_data_o = 0x2_0000_0001, and port_valid_o[3] = 0 afterwards.
REQ-029 SHALL cover: request port 5 while it is empty, then write 0x155 to port 5 ten cycles later -> ack 2 cycles after the write strobe, in_data_o = 0x155.
REQ-030 SHALL cover: write port 7 twice without a read -> ext_ready_o = 0 on the second write, and the slot keeps the first value on readout.
REQ-031 SHALL cover: hold in_req_i high for 5 cycles after the ack, with port 2 refilled -> only one ack until req drops low and rises again.
REQ-032 SHALL cover: assert reset_i while in WAIT on port 1 with ports 0 and 4 full -> next cycle in_ack_o = 0, port_valid_o = 0, FSM in IDLE.
REQ-033 SHALL cover, with IN_PORT_TIMEOUT_EN defined and TIMEOUT = 8: request empty port 9 -> ack after 8 WAIT cycles with in_data_o = 0x2_0000_0000.

Source files
------------

// File: rtl/in_port_bank.sv
// in_port_bank: per-port one-word mailboxes read over a four-phase req/ack handshake; IN_PORT_TIMEOUT_EN adds a forced ack after TIMEOUT cycles in WAIT
module in_port_bank #(
  parameter int D_WIDTH  = 34,
  parameter int PA_WIDTH = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clock,
  input  logic                     reset_i,
  input  logic                     in_req_i,
  input  logic [PA_WIDTH-1:0]      in_addr_i,
  output logic [D_WIDTH-1:0]       in_data_o,
  output logic                     in_ack_o,
  input  logic                     ext_wr_i,
  input  logic [PA_WIDTH-1:0]      ext_addr_i,
  input  logic [D_WIDTH-1:0]       ext_data_i,
  output logic                     ext_ready_o,
  output logic [2**PA_WIDTH-1:0]   port_valid_o
);
  localparam int NP = 2**PA_WIDTH;
  if (TIMEOUT < 1) $error("in_port_bank: TIMEOUT must be at least 1");
  typedef enum logic [1:0] {IDLE, WAIT, ACK, RELEASE} state_t;
  state_t              state_q;
  logic [D_WIDTH-1:0]  slot_q [NP];
  logic [NP-1:0]       valid_q, valid_d;
  logic [PA_WIDTH-1:0] addr_q, take_addr;
  logic [D_WIDTH-1:0]  data_q;
  logic                ack_q, wr_en, take, tmo;
  assign ext_ready_o  = !valid_q[ext_addr_i];
  assign wr_en        = ext_wr_i && ext_ready_o && !reset_i;
  assign take_addr    = state_q == IDLE ? in_addr_i : addr_q;
  assign take         = state_q == IDLE ? in_req_i && valid_q[in_addr_i] : state_q == WAIT && valid_q[addr_q];
  assign in_data_o    = data_q;
  assign in_ack_o     = ack_q;
  assign port_valid_o = valid_q;
`ifdef IN_PORT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  assign tmo = state_q == WAIT && !valid_q[addr_q] && cnt_q == CW'(TIMEOUT - 1);
  // WAIT cycle counter, cleared whenever the FSM is outside WAIT
  always_ff @(posedge clock) begin
    if (reset_i) cnt_q <= '0;
    else cnt_q <= state_q == WAIT ? cnt_q + 1'b1 : '0;
  end
`else
  assign tmo = 1'b0;
`endif
  // Slot fill on an accepted write; a taken slot is set and cleared in different cycles by construction
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[ext_addr_i] = 1'b1;
    if (take) valid_d[take_addr] = 1'b0;
  end
  // Valid flags reset with the bank; data slots need no reset since valid gates them
  always_ff @(posedge clock) begin
    if (reset_i) valid_q <= '0;
    else valid_q <= valid_d;
  end
  // Slot data storage
  always_ff @(posedge clock) begin
    if (wr_en) slot_q[ext_addr_i] <= ext_data_i;
  end
  // Handshake FSM with registered ack and data; data holds until the next ack
  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      ack_q <= take || tmo;
      if (take) data_q <= slot_q[take_addr];
      else if (tmo) data_q <= {1'b1, {(D_WIDTH-1){1'b0}}};
      case (state_q)
        IDLE: if (in_req_i) begin
          addr_q  <= in_addr_i;
          state_q <= take ? ACK : WAIT;
        end
        WAIT:    if (take || tmo) state_q <= ACK;
        ACK:     state_q <= RELEASE;
        RELEASE: if (!in_req_i) state_q <= IDLE;
      endcase
    end
  end
endmodule
